// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with a windowed pixel fetch port.
// Two registered stages keep sync, DE and RGB aligned at the pins.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   iPixel              {R,G,B} for the coordinate requested one pixel earlier
//   iBorderEn           fill active area outside the window with iBorderColor
//   iBorderColor        border colour {R,G,B}
//   oPixEn              pixel-enable strobe, one clock wide
//   oPixReq             window coordinate valid (stage 1)
//   oWinCol, oWinRow    window coordinate, 0 when oPixReq is low
//   oPixel              RGB to DAC (stage 2)
//   oHSync, oVSync      syncs at the configured polarity (stage 2)
//   oDE                 active-video enable (stage 2)
//   oLineStart          pulse when stage 2 shows h = 0
//   oFrameStart         pulse when stage 2 shows h = 0, v = 0
//
// The window must lie inside the active area:
// WIN_X + WIN_W <= H_ACTIVE and WIN_Y + WIN_H <= V_ACTIVE.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned WIN_X    = 192,
  parameter int unsigned WIN_Y    = 112,
  parameter int unsigned WIN_W    = 256,
  parameter int unsigned WIN_H    = 256,
  parameter int unsigned COLOR_W  = 1,
  parameter int unsigned COORD_W  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3*COLOR_W-1:0]   iPixel,
  input  logic                   iBorderEn,
  input  logic [3*COLOR_W-1:0]   iBorderColor,
  output logic                   oPixEn,
  output logic                   oPixReq,
  output logic [COORD_W-1:0]     oWinCol,
  output logic [COORD_W-1:0]     oWinRow,
  output logic [3*COLOR_W-1:0]   oPixel,
  output logic                   oHSync,
  output logic                   oVSync,
  output logic                   oDE,
  output logic                   oLineStart,
  output logic                   oFrameStart
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W   = $clog2(H_TOT);
  localparam int unsigned V_W   = $clog2(V_TOT);
  localparam int unsigned D_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam int unsigned HS_LO = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_LO = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI = V_ACTIVE + V_FP + V_SYNC;

  logic [D_W-1:0] div;
  logic           pix_en;

  // With CLK_DIV = 1 the divider sits at 0 and pix_en stays high.
  assign pix_en = (div == D_W'(CLK_DIV - 1));
  assign oPixEn = pix_en;

  always_ff @(posedge clock) begin
    if (reset)       div <= '0;
    else if (pix_en) div <= '0;
    else             div <= div + 1'b1;
  end

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           h_last;
  logic           v_last;

  assign h_last = (h == H_W'(H_TOT - 1));
  assign v_last = (v == V_W'(V_TOT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      h <= h_last ? '0 : h + 1'b1;
      if (h_last)
        v <= v_last ? '0 : v + 1'b1;
    end
  end

  logic [31:0]        hx;
  logic [31:0]        vx;
  logic               de0;
  logic               hs0;
  logic               vs0;
  logic               hit0;
  logic [COORD_W-1:0] col0;
  logic [COORD_W-1:0] row0;

  assign hx   = 32'(h);
  assign vx   = 32'(v);
  assign de0  = (hx < H_ACTIVE) && (vx < V_ACTIVE);
  assign hs0  = (hx >= HS_LO) && (hx < HS_HI);
  assign vs0  = (vx >= VS_LO) && (vx < VS_HI);
  assign hit0 = (hx >= WIN_X) && (hx < WIN_X + WIN_W) &&
                (vx >= WIN_Y) && (vx < WIN_Y + WIN_H);
  assign col0 = COORD_W'(hx - WIN_X);
  assign row0 = COORD_W'(vx - WIN_Y);

  logic de1;
  logic hs1;
  logic vs1;
  logic lz1;
  logic fz1;

  always_ff @(posedge clock) begin
    if (reset) begin
      oPixReq <= 1'b0;
      oWinCol <= '0;
      oWinRow <= '0;
      de1     <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      lz1     <= 1'b0;
      fz1     <= 1'b0;
    end else if (pix_en) begin
      oPixReq <= hit0;
      oWinCol <= hit0 ? col0 : '0;
      oWinRow <= hit0 ? row0 : '0;
      de1     <= de0;
      hs1     <= hs0;
      vs1     <= vs0;
      lz1     <= (h == '0);
      fz1     <= (h == '0) && (v == '0);
    end
  end

  logic [3*COLOR_W-1:0] pix2;

  // Window data wins; border only inside the active area.
  always_comb begin
    pix2 = '0;
    if (oPixReq)
      pix2 = iPixel;
    else if (de1 && iBorderEn)
      pix2 = iBorderColor;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      oPixel      <= '0;
      oDE         <= 1'b0;
      oHSync      <= ~HS_POL;
      oVSync      <= ~VS_POL;
      oLineStart  <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      // Pulses last only for the clock that follows the strobe.
      oLineStart  <= pix_en & lz1;
      oFrameStart <= pix_en & fz1;
      if (pix_en) begin
        oPixel <= pix2;
        oDE    <= de1;
        oHSync <= hs1 ^ ~HS_POL;
        oVSync <= vs1 ^ ~VS_POL;
      end
    end
  end

endmodule
